// File: rtl/axi4_lite_slave_pkg.sv
// Shared definitions for the AXI4-Lite slave front end:
// FSM state encodings and AXI response codes.
package axi4_lite_slave_pkg;

    typedef enum logic [1:0] {
        W_ACCEPT = 2'd0,
        W_PULSE  = 2'd1,
        W_WAIT   = 2'd2,
        W_RESP   = 2'd3
    } wstate_t;

    typedef enum logic [1:0] {
        R_ACCEPT = 2'd0,
        R_PULSE  = 2'd1,
        R_WAIT   = 2'd2,
        R_RESP   = 2'd3
    } rstate_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/axi4_lite_slave.sv
// AXI4-Lite slave that hands each transaction to user logic as a one-cycle
// request pulse and returns the user's response once it reports idle.
// The write and read paths are fully independent FSMs.
module axi4_lite_slave
    import axi4_lite_slave_pkg::*;
#(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 32
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESET,
    // write address
    input  logic [C_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                          S_AXI_AWVALID,
    input  logic [2:0]                    S_AXI_AWPROT,
    output logic                          S_AXI_AWREADY,
    // write data
    input  logic [C_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    // write response
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    // read address
    input  logic [C_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                          S_AXI_ARVALID,
    input  logic [2:0]                    S_AXI_ARPROT,
    output logic                          S_AXI_ARREADY,
    // read data
    output logic [C_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    // user write side
    output logic [C_AXI_ADDR_WIDTH-1:0]   ASHI_WADDR,
    output logic [C_AXI_DATA_WIDTH-1:0]   ASHI_WDATA,
    output logic [C_AXI_DATA_WIDTH/8-1:0] ASHI_WSTRB,
    output logic                          ASHI_WRITE,
    input  logic [1:0]                    ASHI_WRESP,
    input  logic                          ASHI_WIDLE,
    // user read side
    output logic [C_AXI_ADDR_WIDTH-1:0]   ASHI_RADDR,
    output logic                          ASHI_READ,
    input  logic [C_AXI_DATA_WIDTH-1:0]   ASHI_RDATA,
    input  logic [1:0]                    ASHI_RRESP,
    input  logic                          ASHI_RIDLE
);

    // Protection bits carry no meaning for this slave.
    logic prot_unused;
    assign prot_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    // ---------------- write path ----------------
    wstate_t w_state, w_next;
    logic    aw_got, w_got;
    logic    aw_hs, w_hs, aw_done, w_done;

    assign aw_hs   = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs    = S_AXI_WVALID  & S_AXI_WREADY;
    // A channel counts as captured if it was taken earlier or is taken now.
    assign aw_done = aw_got | aw_hs;
    assign w_done  = w_got  | w_hs;

    assign ASHI_WRITE = (w_state == W_PULSE);

    // Write next-state: collect AW and W in any order, pulse, wait, respond.
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_ACCEPT: if (aw_done && w_done) w_next = W_PULSE;
            W_PULSE:  w_next = W_WAIT;   // WIDLE ignored in the pulse cycle
            W_WAIT:   if (ASHI_WIDLE) w_next = W_RESP;
            W_RESP:   if (S_AXI_BREADY) w_next = W_ACCEPT;
            default:  w_next = W_ACCEPT;
        endcase
    end

    // Write state, channel readies, captured request and B response.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            w_state       <= W_ACCEPT;
            aw_got        <= 1'b0;
            w_got         <= 1'b0;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= OKAY;
            ASHI_WADDR    <= '0;
            ASHI_WDATA    <= '0;
            ASHI_WSTRB    <= '0;
        end else begin
            w_state <= w_next;
            // Capture flags live only while still collecting the pair.
            aw_got  <= (w_state == W_ACCEPT) && (w_next == W_ACCEPT) && aw_done;
            w_got   <= (w_state == W_ACCEPT) && (w_next == W_ACCEPT) && w_done;
            // Each ready drops the cycle after its own handshake and comes
            // back when the FSM returns to accepting.
            S_AXI_AWREADY <= (w_next == W_ACCEPT) && !((w_state == W_ACCEPT) && aw_done);
            S_AXI_WREADY  <= (w_next == W_ACCEPT) && !((w_state == W_ACCEPT) && w_done);
            if (aw_hs)
                ASHI_WADDR <= S_AXI_AWADDR;
            if (w_hs) begin
                ASHI_WDATA <= S_AXI_WDATA;
                ASHI_WSTRB <= S_AXI_WSTRB;
            end
            if ((w_state == W_WAIT) && ASHI_WIDLE)
                S_AXI_BRESP <= ASHI_WRESP;
            S_AXI_BVALID <= (w_next == W_RESP);
        end
    end

    // ---------------- read path ----------------
    rstate_t r_state, r_next;
    logic    ar_hs;

    assign ar_hs     = S_AXI_ARVALID & S_AXI_ARREADY;
    assign ASHI_READ = (r_state == R_PULSE);

    // Read next-state: accept address, pulse, wait for idle, respond.
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_ACCEPT: if (ar_hs) r_next = R_PULSE;
            R_PULSE:  r_next = R_WAIT;
            R_WAIT:   if (ASHI_RIDLE) r_next = R_RESP;
            R_RESP:   if (S_AXI_RREADY) r_next = R_ACCEPT;
            default:  r_next = R_ACCEPT;
        endcase
    end

    // Read state, ARREADY, captured address and R response.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_state       <= R_ACCEPT;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= OKAY;
            ASHI_RADDR    <= '0;
        end else begin
            r_state       <= r_next;
            S_AXI_ARREADY <= (r_next == R_ACCEPT);
            if (ar_hs)
                ASHI_RADDR <= S_AXI_ARADDR;
            if ((r_state == R_WAIT) && ASHI_RIDLE) begin
                S_AXI_RDATA <= ASHI_RDATA;
                S_AXI_RRESP <= ASHI_RRESP;
            end
            S_AXI_RVALID <= (r_next == R_RESP);
        end
    end

endmodule

// File: tb/tb_axi4_lite_slave.sv
// Directed bench for axi4_lite_slave: inputs change and outputs are sampled
// on the falling edge, all expected values are hand-computed constants.
module tb_axi4_lite_slave;
    import axi4_lite_slave_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rdata_u = '0;
    logic [3:0]  wstrb = '0;
    logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic [1:0]  wresp_u = OKAY, rresp_u = OKAY;
    logic        widle = 0, ridle = 0;

    logic        awready, wready, bvalid, arready, rvalid, ashi_write, ashi_read;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata, ashi_waddr, ashi_wdata, ashi_raddr;
    logic [3:0]  ashi_wstrb;

    int n_cmp = 0;
    int n_err = 0;
    int wr_pulses = 0;
    int rd_pulses = 0;
    int base;
    logic ok;

    always #5 clk = ~clk;

    axi4_lite_slave dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWPROT(3'b000),
        .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid),
        .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARPROT(3'b000),
        .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid),
        .S_AXI_RREADY(rready),
        .ASHI_WADDR(ashi_waddr), .ASHI_WDATA(ashi_wdata), .ASHI_WSTRB(ashi_wstrb),
        .ASHI_WRITE(ashi_write), .ASHI_WRESP(wresp_u), .ASHI_WIDLE(widle),
        .ASHI_RADDR(ashi_raddr), .ASHI_READ(ashi_read),
        .ASHI_RDATA(rdata_u), .ASHI_RRESP(rresp_u), .ASHI_RIDLE(ridle)
    );

    // Count request pulses to prove exactly one per transaction.
    always @(posedge clk) begin
        if (ashi_write) wr_pulses <= wr_pulses + 1;
        if (ashi_read)  rd_pulses <= rd_pulses + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // ---- reset state ----
        #2;
        chk("rst_ready", {29'd0, awready, wready, arready}, 32'd0);
        chk("rst_valid", {28'd0, bvalid, rvalid, ashi_write, ashi_read}, 32'd0);
        chk("rst_data",  ashi_waddr | ashi_wdata | ashi_raddr | rdata, 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("ready_after_rst", {29'd0, awready, wready, arready}, 32'h7);

        // ---- AW and W together, WIDLE high ----
        awaddr = 32'h10; wdata = 32'hDEADBEEF; wstrb = 4'hF;
        awvalid = 1; wvalid = 1; widle = 1; wresp_u = OKAY;
        step();
        awvalid = 0; wvalid = 0;
        chk("t1_ready_drop", {30'd0, awready, wready}, 32'd0);
        chk("t1_pulse", {31'd0, ashi_write}, 32'd1);
        chk("t1_waddr", ashi_waddr, 32'h10);
        chk("t1_wdata", ashi_wdata, 32'hDEADBEEF);
        chk("t1_wstrb", {28'd0, ashi_wstrb}, 32'hF);
        step();
        chk("t1_pulse_end", {30'd0, ashi_write, bvalid}, 32'd0);
        step();
        chk("t1_bvalid", {29'd0, bvalid, bresp}, {29'd0, 1'b1, OKAY});
        bready = 1;
        step();
        bready = 0;
        chk("t1_b_done", {29'd0, bvalid, awready, wready}, 32'h3);

        // ---- W three cycles before AW, SLVERR held under BREADY stall ----
        base = wr_pulses;
        wdata = 32'h5; wstrb = 4'h3; wvalid = 1; wresp_u = SLVERR;
        step();
        wvalid = 0; wdata = 32'hFFFF_FFFF;
        chk("t2_wready_drop", {30'd0, wready, awready}, 32'h1);
        ok = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (ashi_write || wready) ok = 0;
        end
        chk("t2_no_early_pulse", {31'd0, ok}, 32'd1);
        awaddr = 32'h24; awvalid = 1;
        step();
        awvalid = 0;
        chk("t2_pulse", {31'd0, ashi_write}, 32'd1);
        chk("t2_waddr", ashi_waddr, 32'h24);
        chk("t2_wdata", ashi_wdata, 32'h5);
        step(2);
        chk("t2_bvalid", {29'd0, bvalid, bresp}, {29'd0, 1'b1, SLVERR});
        wresp_u = DECERR;
        ok = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (!bvalid || bresp !== SLVERR || awready || wready) ok = 0;
        end
        chk("t2_b_stall_hold", {31'd0, ok}, 32'd1);
        bready = 1;
        step();
        bready = 0;
        chk("t2_b_done", {31'd0, bvalid}, 32'd0);
        chk("t2_one_pulse", wr_pulses - base, 32'd1);

        // ---- read with RIDLE low five cycles, SLVERR, then RREADY stall ----
        ridle = 0; araddr = 32'h08; arvalid = 1;
        step();
        arvalid = 0;
        chk("t3_rpulse", {31'd0, ashi_read}, 32'd1);
        chk("t3_raddr", ashi_raddr, 32'h08);
        ok = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (arready || rvalid || ashi_read) ok = 0;
        end
        chk("t3_wait_quiet", {31'd0, ok}, 32'd1);
        rdata_u = 32'h12345678; rresp_u = SLVERR; ridle = 1;
        step();
        chk("t3_rvalid", {29'd0, rvalid, rresp}, {29'd0, 1'b1, SLVERR});
        chk("t3_rdata", rdata, 32'h12345678);
        rdata_u = 32'h0BAD0BAD; rresp_u = DECERR;
        ok = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (!rvalid || rdata !== 32'h12345678 || rresp !== SLVERR || arready) ok = 0;
        end
        chk("t3_r_stall_hold", {31'd0, ok}, 32'd1);
        rready = 1;
        step();
        rready = 0;
        chk("t3_r_done", {30'd0, rvalid, arready}, 32'h1);
        chk("t3_one_rpulse", rd_pulses, 32'd1);

        // ---- concurrent write 0x30 and read 0x34 ----
        awaddr = 32'h30; wdata = 32'hA5A5A5A5; wstrb = 4'hF; wresp_u = OKAY; widle = 1;
        araddr = 32'h34; rdata_u = 32'hCAFE0034; rresp_u = OKAY; ridle = 1;
        awvalid = 1; wvalid = 1; arvalid = 1;
        step();
        awvalid = 0; wvalid = 0; arvalid = 0;
        chk("t4_both_pulse", {30'd0, ashi_write, ashi_read}, 32'h3);
        chk("t4_waddr", ashi_waddr, 32'h30);
        chk("t4_raddr", ashi_raddr, 32'h34);
        step(2);
        chk("t4_both_valid", {30'd0, bvalid, rvalid}, 32'h3);
        chk("t4_rdata", rdata, 32'hCAFE0034);
        chk("t4_resps", {28'd0, bresp, rresp}, 32'd0);
        bready = 1; rready = 1;
        step();
        bready = 0; rready = 0;
        chk("t4_done", {28'd0, bvalid, rvalid, awready, arready}, 32'h3);

        // ---- reset while waiting on the user write ----
        widle = 0; awaddr = 32'h50; wdata = 32'h77; awvalid = 1; wvalid = 1;
        step();
        awvalid = 0; wvalid = 0;
        step();
        rst = 1'b1;
        #1;
        chk("t5_rst_ready", {29'd0, awready, wready, arready}, 32'd0);
        chk("t5_rst_out", {30'd0, bvalid, ashi_write} | ashi_waddr | ashi_wdata, 32'd0);
        widle = 1; bready = 1;
        step(2);
        rst = 1'b0;
        ok = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bvalid) ok = 0;
        end
        chk("t5_no_bresp", {31'd0, ok}, 32'd1);
        chk("t5_ready_back", {29'd0, awready, wready, arready}, 32'h7);
        bready = 0;
        awaddr = 32'h40; wdata = 32'h40404040; wstrb = 4'hC; awvalid = 1; wvalid = 1;
        step();
        awvalid = 0; wvalid = 0;
        chk("t5_pulse", {31'd0, ashi_write}, 32'd1);
        chk("t5_waddr", ashi_waddr, 32'h40);
        chk("t5_wdata", ashi_wdata, 32'h40404040);
        step(2);
        chk("t5_bvalid", {29'd0, bvalid, bresp}, {29'd0, 1'b1, OKAY});
        bready = 1;
        step();
        bready = 0;
        chk("t5_b_done", {29'd0, bvalid, awready, wready}, 32'h3);
        chk("total_wr_pulses", wr_pulses, 32'd5);
        chk("total_rd_pulses", rd_pulses, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
